// File: rtl/fx_pkg.sv
// Shared types for the FX parameter controller: parameter ids, slot numbers,
// the queued write record and the controller state encoding.
package fx_pkg;

    localparam int FX_DEF_NUM     = 8;
    localparam int FX_DEF_ID_W    = $clog2(FX_DEF_NUM);
    localparam int FX_DEF_PARAM_W = 8;

    // Slot assignment in the rack
    localparam int FX_EQ      = 0;
    localparam int FX_COMP    = 1;
    localparam int FX_DRIVE   = 2;
    localparam int FX_DELAY   = 3;
    localparam int FX_REVERB  = 4;
    localparam int FX_CHORUS  = 5;
    localparam int FX_FLANGER = 6;
    localparam int FX_PHASER  = 7;

    typedef enum logic [1:0] {P_RATE, P_DEPTH, P_MIX, P_RSVD} fx_param_e;

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_COMMIT} fx_ctrl_state_e;

    typedef struct packed {
        logic [FX_DEF_ID_W-1:0]    fx_id;
        fx_param_e                 param_id;
        logic [FX_DEF_PARAM_W-1:0] data;
    } fx_param_wr_t;

endpackage

// File: rtl/fx_param_fifo.sv
// Synchronous FIFO of parameter writes. DEPTH must be a power of two so the
// pointers wrap naturally; the count register separates full from empty.
module fx_param_fifo
    import fx_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fx_param_wr_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fx_param_ctrl.sv
// FX rack parameter controller: queues writes, drains them into shadow registers
// and copies shadow to active on sample strobes. Optional mix slew: FX_PARAM_SLEW_EN.
//
// Handshake: a write transfers on a rising clk edge where wr_valid && wr_ready.
// wr_ready depends only on registered FIFO occupancy, never on wr_valid; the
// writer must hold wr_fx_id/wr_param_id/wr_data stable while wr_valid is high.
module fx_param_ctrl
    import fx_pkg::*;
#(
    parameter int NUM_FX     = 8,
    parameter int PARAM_W    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SLEW_STEP  = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             sample_en,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [$clog2(NUM_FX)-1:0]        wr_fx_id,
    input  logic [1:0]                       wr_param_id,
    input  logic [PARAM_W-1:0]               wr_data,
    input  logic                             err_clr,
    output logic [NUM_FX-1:0][PARAM_W-1:0]   fx_rate,
    output logic [NUM_FX-1:0][PARAM_W-1:0]   fx_depth,
    output logic [NUM_FX-1:0][PARAM_W-1:0]   fx_mix,
    output logic                             commit_pulse,
    output logic                             busy,
    output logic                             err_sticky,
    output fx_ctrl_state_e                   dbg_state
);

    localparam int FX_ID_W = $clog2(NUM_FX);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [FX_ID_W-1:0] fx_id;
        fx_param_e          param_id;
        logic [PARAM_W-1:0] data;
    } wr_t;

    typedef logic [NUM_FX-1:0][PARAM_W-1:0] bank_t;

    fx_ctrl_state_e state_q, state_d;
    wr_t            in_wr, head;
    logic           push, pop, full, empty, head_ok;
    logic [CW-1:0]  fifo_count;
    bank_t          rate_sh, depth_sh, mix_sh;
    bank_t          rate_act, depth_act, mix_act;
    logic           mix_unsettled;

    assign in_wr.fx_id    = wr_fx_id;
    assign in_wr.param_id = fx_param_e'(wr_param_id);
    assign in_wr.data     = wr_data;
    assign wr_ready       = !full;
    assign push           = wr_valid && wr_ready;

    fx_param_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (wr_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (in_wr),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign head_ok = (32'(head.fx_id) < NUM_FX) && (head.param_id != P_RSVD);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // A strobe always wins over a pending pop so nothing lands in shadow mid-commit.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sample_en)   state_d = ST_COMMIT;
                else if (!empty) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (sample_en) begin
                    state_d = ST_COMMIT;
                end else if (empty) begin
                    state_d = ST_IDLE;
                end else begin
                    pop = 1'b1;
                    if (fifo_count == CW'(1) && !push) state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (sample_en)   state_d = ST_COMMIT;
                else if (!empty) state_d = ST_DRAIN;
                else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rate_sh    <= '0;
            depth_sh   <= '0;
            mix_sh     <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (pop && head_ok) begin
                case (head.param_id)
                    P_RATE:  rate_sh[head.fx_id]  <= head.data;
                    P_DEPTH: depth_sh[head.fx_id] <= head.data;
                    P_MIX:   mix_sh[head.fx_id]   <= head.data;
                    default: ;
                endcase
            end
            if (pop && !head_ok) err_sticky <= 1'b1;
            else if (err_clr)    err_sticky <= 1'b0;
        end
    end

`ifdef FX_PARAM_SLEW_EN
    localparam logic [PARAM_W-1:0] STEP = PARAM_W'(SLEW_STEP);
    bank_t mix_next;

    // Step toward the shadow value, snapping onto it once within one step.
    always_comb begin
        mix_next      = mix_act;
        mix_unsettled = 1'b0;
        for (int i = 0; i < NUM_FX; i++) begin
            if (mix_act[i] != mix_sh[i]) mix_unsettled = 1'b1;
            if (mix_sh[i] > mix_act[i]) begin
                mix_next[i] = ((mix_sh[i] - mix_act[i]) > STEP) ? (mix_act[i] + STEP) : mix_sh[i];
            end else if (mix_sh[i] < mix_act[i]) begin
                mix_next[i] = ((mix_act[i] - mix_sh[i]) > STEP) ? (mix_act[i] - STEP) : mix_sh[i];
            end
        end
    end
`else
    bank_t mix_next;
    assign mix_next      = mix_sh;
    assign mix_unsettled = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rate_act     <= '0;
            depth_act    <= '0;
            mix_act      <= '0;
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= (state_q == ST_COMMIT);
            if (state_q == ST_COMMIT) begin
                rate_act  <= rate_sh;
                depth_act <= depth_sh;
                mix_act   <= mix_next;
            end
        end
    end

    assign fx_rate   = rate_act;
    assign fx_depth  = depth_act;
    assign fx_mix    = mix_act;
    assign busy      = !empty || (state_q != ST_IDLE) || mix_unsettled;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fx_param_ctrl.sv
// Directed bench for fx_param_ctrl: a write/commit vector table plus hand-built
// sequences for FIFO backpressure, strobe-vs-pop, error flag and reset.
module tb_fx_param_ctrl;
    import fx_pkg::*;

    logic              clk;
    logic              reset_n;
    logic              sample_en;
    logic              wr_valid;
    logic              wr_ready;
    logic [2:0]        wr_fx_id;
    logic [1:0]        wr_param_id;
    logic [7:0]        wr_data;
    logic              err_clr;
    logic [7:0][7:0]   fx_rate;
    logic [7:0][7:0]   fx_depth;
    logic [7:0][7:0]   fx_mix;
    logic              commit_pulse;
    logic              busy;
    logic              err_sticky;
    fx_ctrl_state_e    dbg_state;

    int tests_run;
    int tests_failed;
    logic [23:0] exp_q[$];

    fx_param_ctrl #(
        .NUM_FX     (8),
        .PARAM_W    (8),
        .FIFO_DEPTH (4),
        .SLEW_STEP  (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_en    (sample_en),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_fx_id     (wr_fx_id),
        .wr_param_id  (wr_param_id),
        .wr_data      (wr_data),
        .err_clr      (err_clr),
        .fx_rate      (fx_rate),
        .fx_depth     (fx_depth),
        .fx_mix       (fx_mix),
        .commit_pulse (commit_pulse),
        .busy         (busy),
        .err_sticky   (err_sticky),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] fx, input logic [1:0] p, input logic [7:0] d);
        logic acc;
        acc         = 1'b0;
        wr_fx_id    = fx;
        wr_param_id = p;
        wr_data     = d;
        wr_valid    = 1'b1;
        for (int i = 0; i < 32 && !acc; i++) begin
            acc = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        check("write_accept", acc, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            tick();
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic strobe_once();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check("pulse_early", commit_pulse, 0);
        tick();
        check("commit_pulse", commit_pulse, 1);
    endtask

    // Keep strobing while a slewed mix is still moving; returns the extra strobes used.
    task automatic settle(output int n);
        n = 0;
        while (busy && n < 100) begin
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            tick();
            n++;
        end
        check("settled", busy, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] fx;
        logic [1:0] param;
        logic [7:0] data;
        logic [7:0] exp_rate;
        logic [7:0] exp_depth;
        logic [7:0] exp_mix;
        logic       exp_err;
    } vec_t;

    vec_t vecs [6];

`ifdef FX_PARAM_SLEW_EN
    localparam logic [7:0] MIX_FIRST = 8'h04;
    localparam int         EXTRA_N   = 31;
`else
    localparam logic [7:0] MIX_FIRST = 8'h80;
    localparam int         EXTRA_N   = 0;
`endif

    initial begin
        int n;
        logic [63:0] snap_r, snap_d, snap_m;
        logic [23:0] exp_v;
        logic [1:0]  t3_p [5];
        logic [7:0]  t3_d [5];

        vecs[0] = '{3'd0, P_RATE,  8'h12, 8'h12, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{3'd0, P_DEPTH, 8'h34, 8'h12, 8'h34, 8'h00, 1'b0};
        vecs[2] = '{3'd7, P_MIX,   8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0};
        vecs[3] = '{3'd3, P_RATE,  8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{3'd0, P_RATE,  8'hAB, 8'hAB, 8'h34, 8'h00, 1'b0};
        vecs[5] = '{3'd2, P_RSVD,  8'h11, 8'h00, 8'h00, 8'h00, 1'b1};
        t3_p = '{P_RATE, P_RATE, P_DEPTH, P_RATE, P_MIX};
        t3_d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};

        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        sample_en    = 1'b0;
        wr_valid     = 1'b0;
        wr_fx_id     = '0;
        wr_param_id  = '0;
        wr_data      = '0;
        err_clr      = 1'b0;

        // 1. reset state
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_rate",   fx_rate,  64'h0);
        check("rst_depth",  fx_depth, 64'h0);
        check("rst_mix",    fx_mix,   64'h0);
        check("rst_ready",  wr_ready, 1);
        check("rst_busy",   busy, 0);
        check("rst_err",    err_sticky, 0);
        check("rst_pulse",  commit_pulse, 0);
        check("rst_state",  dbg_state, ST_IDLE);

        // 2. chorus mix write, nothing visible until the strobe, then 2-cycle latency
        do_write(3'(FX_CHORUS), P_MIX, 8'h80);
        wait_idle();
        tick();
        tick();
        check("mix5_pre_strobe", fx_mix[FX_CHORUS], 8'h00);
        check("pulse_pre_strobe", commit_pulse, 0);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        check("mix5_lat1", fx_mix[FX_CHORUS], 8'h00);
        check("pulse_lat1", commit_pulse, 0);
        tick();
        check("mix5_lat2", fx_mix[FX_CHORUS], MIX_FIRST);
        check("pulse_lat2", commit_pulse, 1);
        settle(n);
        check("mix5_extra_samples", n, EXTRA_N);
        check("mix5_final", fx_mix[FX_CHORUS], 8'h80);

        // table: one write, one commit, check the target slot
        for (int v = 0; v < 6; v++) begin
            snap_r = fx_rate;
            snap_d = fx_depth;
            snap_m = fx_mix;
            exp_q.push_back({vecs[v].exp_rate, vecs[v].exp_depth, vecs[v].exp_mix});
            do_write(vecs[v].fx, vecs[v].param, vecs[v].data);
            wait_idle();
            strobe_once();
            settle(n);
            exp_v = exp_q.pop_front();
            check($sformatf("vec%0d_rate", v),  fx_rate[vecs[v].fx],  exp_v[23:16]);
            check($sformatf("vec%0d_depth", v), fx_depth[vecs[v].fx], exp_v[15:8]);
            check($sformatf("vec%0d_mix", v),   fx_mix[vecs[v].fx],   exp_v[7:0]);
            check($sformatf("vec%0d_err", v),   err_sticky, vecs[v].exp_err);
            if (vecs[v].exp_err) begin
                check($sformatf("vec%0d_rate_hold", v),  fx_rate,  snap_r);
                check($sformatf("vec%0d_depth_hold", v), fx_depth, snap_d);
                check($sformatf("vec%0d_mix_hold", v),   fx_mix,   snap_m);
            end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", err_sticky, 0);
        // fx_id 9 cannot be expressed on a 3-bit wr_fx_id, so only param_id 3 is illegal here.

        // 3. FSM parked in COMMIT by a held strobe: FIFO fills, 5th write refused
        sample_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            wr_fx_id    = 3'd1;
            wr_param_id = t3_p[i];
            wr_data     = t3_d[i];
            wr_valid    = 1'b1;
            check($sformatf("fill_ready_%0d", i), wr_ready, (i < 4));
            tick();
        end
        wr_valid  = 1'b0;
        sample_en = 1'b0;
        wait_idle();
        check("fill_rate1_uncommitted", fx_rate[1], 8'h00);
        do_write(3'd1, P_MIX, 8'h50);
        wait_idle();
        strobe_once();
        settle(n);
        check("fill_rate1", fx_rate[1],  8'h40);
        check("fill_depth1", fx_depth[1], 8'h30);
        check("fill_mix1", fx_mix[1],   8'h50);

        // 4. strobe in the cycle a second DRAIN pop is due
        sample_en = 1'b1;
        tick();
        wr_fx_id = 3'd4; wr_param_id = P_RATE;  wr_data = 8'h71; wr_valid = 1'b1;
        tick();
        wr_fx_id = 3'd4; wr_param_id = P_DEPTH; wr_data = 8'h72;
        tick();
        wr_valid  = 1'b0;
        sample_en = 1'b0;
        tick();                         // COMMIT -> DRAIN
        check("race_state_drain", dbg_state, ST_DRAIN);
        tick();                         // rate entry popped
        sample_en = 1'b1;
        tick();                         // strobe beats the depth pop
        sample_en = 1'b0;
        check("race_state_commit", dbg_state, ST_COMMIT);
        check("race_rate_pre", fx_rate[4], 8'h00);
        tick();
        check("race_pulse", commit_pulse, 1);
        check("race_rate4", fx_rate[4], 8'h71);
        check("race_depth4_held", fx_depth[4], 8'h00);
        check("race_busy", busy, 1);
        wait_idle();
        check("race_depth4_still_old", fx_depth[4], 8'h00);
        strobe_once();
        settle(n);
        check("race_depth4_next", fx_depth[4], 8'h72);

        // error set wins over a simultaneous clear
        err_clr = 1'b1;
        do_write(3'd3, P_RSVD, 8'h5A);
        wait_idle();
        check("err_set_over_clr", err_sticky, 1);
        err_clr = 1'b0;
        tick();
        check("err_holds", err_sticky, 1);
        check("err_no_change", fx_rate[3], 8'h01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", err_sticky, 0);

        // 6. reset with three writes queued
        sample_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            wr_fx_id    = 3'd6;
            wr_param_id = 2'(i);
            wr_data     = 8'h99 - 8'(i);
            wr_valid    = 1'b1;
            tick();
        end
        wr_valid  = 1'b0;
        sample_en = 1'b0;
        check("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        tick();
        check("mrst_busy",  busy, 0);
        check("mrst_ready", wr_ready, 1);
        check("mrst_pulse", commit_pulse, 0);
        check("mrst_rate",  fx_rate,  64'h0);
        check("mrst_depth", fx_depth, 64'h0);
        check("mrst_mix",   fx_mix,   64'h0);
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        strobe_once();
        settle(n);
        check("post_rst_rate",  fx_rate,  64'h0);
        check("post_rst_depth", fx_depth, 64'h0);
        check("post_rst_mix",   fx_mix,   64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
